// File: rtl/cordic_nxy_out.sv
// Output FIFO and 3-byte frame serializer for CORDIC (nx, ny) result pairs.
// Pairs are drained from the core, buffered, and emitted MSB-first on an 8-bit stream.
module cordic_nxy_out #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       ck,
  input  logic       raz,
  input  logic       rok_nxy_p,
  output logic       rd_nxy_p,
  input  logic [9:0] nx_p,
  input  logic [9:0] ny_p,
  output logic [7:0] out_data_p,
  output logic       out_rok_p,
  input  logic       out_rd_p,
  output logic       busy_p
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} state_e;

  logic [19:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  state_e          state_q, state_d;
  logic [19:0]     frame_q, frame_d;
  logic [7:0]      data_q, data_d;

  logic        push;
  logic        pop;
  logic        not_empty;
  logic [19:0] head;

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rptr_q];

  // Ready depends only on registered count, so there is no loop through the core.
  assign rd_nxy_p = (count_q != CntW'(DEPTH));
  assign push     = rok_nxy_p & rd_nxy_p;

  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = not_empty;
      StB2:    pop = out_rd_p & not_empty;
      default: pop = 1'b0;
    endcase
  end

  // Frame layout is {nx, ny}; the three bytes are consecutive 8-bit slices, last one zero-padded.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StB0;
          frame_d = head;
          data_d  = head[19:12];
        end
      end
      StB0: begin
        if (out_rd_p) begin
          state_d = StB1;
          data_d  = frame_q[11:4];
        end
      end
      StB1: begin
        if (out_rd_p) begin
          state_d = StB2;
          data_d  = {frame_q[3:0], 4'b0000};
        end
      end
      StB2: begin
        if (out_rd_p) begin
          if (pop) begin
            state_d = StB0;
            frame_d = head;
            data_d  = head[19:12];
          end else begin
            state_d = StIdle;
            data_d  = 8'h00;
          end
        end
      end
      default: begin
        state_d = StIdle;
        data_d  = 8'h00;
      end
    endcase
  end

  always_comb begin
    wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d  = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ck or negedge raz) begin
    if (!raz) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      state_q <= StIdle;
      frame_q <= '0;
      data_q  <= 8'h00;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      state_q <= state_d;
      frame_q <= frame_d;
      data_q  <= data_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge ck) begin
    if (push) begin
      mem_q[wptr_q] <= {nx_p, ny_p};
    end
  end

  assign out_data_p = data_q;
  assign out_rok_p  = (state_q != StIdle);
  assign busy_p     = (state_q != StIdle) | not_empty;

endmodule

// File: tb/tb_cordic_nxy_out.sv
// Directed and scoreboard bench for cordic_nxy_out: frame bytes, latency, fill, stall, reset.
module tb_cordic_nxy_out;

  localparam int unsigned DEPTH = 4;

  logic       ck;
  logic       raz;
  logic       rok_nxy_p;
  logic       rd_nxy_p;
  logic [9:0] nx_p;
  logic [9:0] ny_p;
  logic [7:0] out_data_p;
  logic       out_rok_p;
  logic       out_rd_p;
  logic       busy_p;

  cordic_nxy_out #(.DEPTH(DEPTH)) dut (
    .ck         (ck),
    .raz        (raz),
    .rok_nxy_p  (rok_nxy_p),
    .rd_nxy_p   (rd_nxy_p),
    .nx_p       (nx_p),
    .ny_p       (ny_p),
    .out_data_p (out_data_p),
    .out_rok_p  (out_rok_p),
    .out_rd_p   (out_rd_p),
    .busy_p     (busy_p)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  typedef struct {
    logic [9:0] nx;
    logic [9:0] ny;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t vecs [7];
  int   n_cmp;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Reference byte mapping for the random/fill tests.
  function automatic logic [7:0] frame_byte(input logic [9:0] nx, input logic [9:0] ny,
                                            input int k);
    logic [7:0] b;
    case (k)
      0:       b = nx[9:2];
      1:       b = {nx[1:0], ny[9:4]};
      default: b = {ny[3:0], 4'b0000};
    endcase
    return b;
  endfunction

  function automatic logic [19:0] fill_pair(input int i);
    logic [9:0] x;
    logic [9:0] y;
    x = 10'(i * 71 + 5);
    y = 10'(i * 113 + 300);
    return {x, y};
  endfunction

  task automatic check_idle(input string name);
    check({name, "_rok"}, 32'(out_rok_p), 32'd0);
    check({name, "_data"}, 32'(out_data_p), 32'h00);
    check({name, "_busy"}, 32'(busy_p), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  exp_b [9];
    logic [19:0] pr;
    logic [19:0] q [$];
    int          p;
    int          bidx;
    int          sent;
    int          recv;
    int          cyc;
    logic        s_rd;
    logic        s_rok;
    logic [7:0]  s_data;
    logic        d_rok;
    logic        d_ord;

    n_cmp  = 0;
    n_fail = 0;

    vecs[0] = '{10'h2A5, 10'h0F3, 8'hA9, 8'h4F, 8'h30};
    vecs[1] = '{10'h3FF, 10'h3FF, 8'hFF, 8'hFF, 8'hF0};
    vecs[2] = '{10'h000, 10'h000, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{10'h200, 10'h001, 8'h80, 8'h00, 8'h10};
    vecs[4] = '{10'h003, 10'h200, 8'h00, 8'hE0, 8'h00};
    vecs[5] = '{10'h155, 10'h2AA, 8'h55, 8'h6A, 8'hA0};
    vecs[6] = '{10'h1C7, 10'h38E, 8'h71, 8'hF8, 8'hE0};

    raz       = 1'b0;
    rok_nxy_p = 1'b0;
    nx_p      = '0;
    ny_p      = '0;
    out_rd_p  = 1'b0;
    #2;
    check_idle("reset");
    check("reset_rd", 32'(rd_nxy_p), 32'd1);
    tick();
    tick();
    raz = 1'b1;
    tick();

    // Single pairs: latency of two edges, bytes on consecutive cycles, then idle.
    for (int v = 0; v < 7; v++) begin
      out_rd_p  = 1'b1;
      rok_nxy_p = 1'b1;
      nx_p      = vecs[v].nx;
      ny_p      = vecs[v].ny;
      check("single_rd", 32'(rd_nxy_p), 32'd1);
      tick();
      rok_nxy_p = 1'b0;
      check("single_lat_rok", 32'(out_rok_p), 32'd0);
      check("single_lat_busy", 32'(busy_p), 32'd1);
      tick();
      check("single_b0_rok", 32'(out_rok_p), 32'd1);
      check("single_b0", 32'(out_data_p), 32'(vecs[v].b0));
      tick();
      check("single_b1_rok", 32'(out_rok_p), 32'd1);
      check("single_b1", 32'(out_data_p), 32'(vecs[v].b1));
      tick();
      check("single_b2_rok", 32'(out_rok_p), 32'd1);
      check("single_b2", 32'(out_data_p), 32'(vecs[v].b2));
      tick();
      check_idle("single_end");
    end

    // Back-to-back: three pushes give nine gap-free bytes in push order.
    for (int k = 0; k < 3; k++) begin
      exp_b[3*k]   = vecs[4+k].b0;
      exp_b[3*k+1] = vecs[4+k].b1;
      exp_b[3*k+2] = vecs[4+k].b2;
    end
    p = 0;
    out_rd_p = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      if (p < 3) begin
        rok_nxy_p = 1'b1;
        nx_p      = vecs[4+p].nx;
        ny_p      = vecs[4+p].ny;
        p++;
      end else begin
        rok_nxy_p = 1'b0;
      end
      if (c >= 2) begin
        check("b2b_rok", 32'(out_rok_p), 32'd1);
        check("b2b_data", 32'(out_data_p), 32'(exp_b[c-2]));
      end
      tick();
    end
    rok_nxy_p = 1'b0;
    check_idle("b2b_end");

    // Fill: DEPTH+1 transfers with the consumer stalled, then drain.
    out_rd_p = 1'b0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      pr        = fill_pair(i);
      rok_nxy_p = 1'b1;
      nx_p      = pr[19:10];
      ny_p      = pr[9:0];
      check("fill_rd_high", 32'(rd_nxy_p), 32'd1);
      tick();
    end
    check("fill_rd_low", 32'(rd_nxy_p), 32'd0);
    rok_nxy_p = 1'b0;
    tick();
    tick();
    pr = fill_pair(0);
    check("fill_hold_rd", 32'(rd_nxy_p), 32'd0);
    check("fill_hold_rok", 32'(out_rok_p), 32'd1);
    check("fill_hold_data", 32'(out_data_p), 32'(frame_byte(pr[19:10], pr[9:0], 0)));
    out_rd_p = 1'b1;
    for (int j = 0; j < 3 * (int'(DEPTH) + 1); j++) begin
      pr = fill_pair(j / 3);
      if (j <= 3) check("fill_rd_rise", 32'(rd_nxy_p), (j >= 3) ? 32'd1 : 32'd0);
      check("fill_rok", 32'(out_rok_p), 32'd1);
      check("fill_data", 32'(out_data_p), 32'(frame_byte(pr[19:10], pr[9:0], j % 3)));
      tick();
    end
    check_idle("fill_end");
    check("fill_end_rd", 32'(rd_nxy_p), 32'd1);

    // Stall in B1 for five cycles.
    rok_nxy_p = 1'b1;
    nx_p      = vecs[0].nx;
    ny_p      = vecs[0].ny;
    tick();
    rok_nxy_p = 1'b0;
    tick();
    check("stall_b0", 32'(out_data_p), 32'(vecs[0].b0));
    tick();
    out_rd_p = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("stall_rok", 32'(out_rok_p), 32'd1);
      check("stall_data", 32'(out_data_p), 32'(vecs[0].b1));
      tick();
    end
    check("stall_b1_last", 32'(out_data_p), 32'(vecs[0].b1));
    out_rd_p = 1'b1;
    tick();
    check("stall_resume_rok", 32'(out_rok_p), 32'd1);
    check("stall_resume_b2", 32'(out_data_p), 32'(vecs[0].b2));
    tick();
    check_idle("stall_end");

    // Reset mid-frame with two pairs queued.
    out_rd_p = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      rok_nxy_p = 1'b1;
      nx_p      = vecs[k].nx;
      ny_p      = vecs[k].ny;
      tick();
    end
    rok_nxy_p = 1'b0;
    out_rd_p  = 1'b1;
    tick();
    out_rd_p = 1'b0;
    check("rst_pre_b1", 32'(out_data_p), 32'(vecs[1].b1));
    check("rst_pre_rok", 32'(out_rok_p), 32'd1);
    raz = 1'b0;
    #1;
    check("rst_async_rok", 32'(out_rok_p), 32'd0);
    check("rst_async_rd", 32'(rd_nxy_p), 32'd1);
    check("rst_async_busy", 32'(busy_p), 32'd0);
    check("rst_async_data", 32'(out_data_p), 32'h00);
    tick();
    tick();
    raz      = 1'b1;
    out_rd_p = 1'b1;
    for (int s = 0; s < 6; s++) begin
      tick();
      check_idle("rst_after");
    end
    rok_nxy_p = 1'b1;
    nx_p      = vecs[6].nx;
    ny_p      = vecs[6].ny;
    tick();
    rok_nxy_p = 1'b0;
    tick();
    check("rst_new_b0", 32'(out_data_p), 32'(vecs[6].b0));
    tick();
    check("rst_new_b1", 32'(out_data_p), 32'(vecs[6].b1));
    tick();
    check("rst_new_b2", 32'(out_data_p), 32'(vecs[6].b2));
    tick();
    check_idle("rst_new_end");

    // Wrap-around: random handshakes on both sides, scoreboard over 3*DEPTH+1 pairs.
    q.delete();
    sent = 0;
    recv = 0;
    bidx = 0;
    cyc  = 0;
    while (recv < 3 * (3 * int'(DEPTH) + 1) && cyc < 3000) begin
      d_rok = (sent < 3 * int'(DEPTH) + 1) && ($urandom_range(1, 0) == 1);
      d_ord = ($urandom_range(1, 0) == 1);
      pr    = 20'($urandom);
      rok_nxy_p = d_rok;
      nx_p      = pr[19:10];
      ny_p      = pr[9:0];
      out_rd_p  = d_ord;
      s_rd   = rd_nxy_p;
      s_rok  = out_rok_p;
      s_data = out_data_p;
      tick();
      cyc++;
      if (d_rok && s_rd) begin
        q.push_back(pr);
        sent++;
      end
      if (s_rok && d_ord) begin
        if (q.size() == 0) begin
          check("wrap_extra_byte", 32'(s_data), 32'hFFFF_FFFF);
        end else begin
          check("wrap_data", 32'(s_data), 32'(frame_byte(q[0][19:10], q[0][9:0], bidx)));
          bidx++;
          if (bidx == 3) begin
            bidx = 0;
            void'(q.pop_front());
          end
        end
        recv++;
      end
    end
    rok_nxy_p = 1'b0;
    check("wrap_timeout", 32'(cyc < 3000), 32'd1);
    check("wrap_sent", 32'(sent), 32'(3 * DEPTH + 1));
    check("wrap_recv", 32'(recv), 32'(3 * (3 * DEPTH + 1)));
    check("wrap_queue_empty", 32'(q.size()), 32'd0);
    out_rd_p = 1'b1;
    tick();
    tick();
    check_idle("wrap_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
